// File: rtl/xc_pshift_seq_if.sv
// Request/response bundle for xc_pshift_seq: requester drives the i_* side, the shifter drives o_*.
interface xc_pshift_seq_if #(
  parameter int XLEN = 32
);
  localparam int LW = $clog2(XLEN);

  logic            i_valid;
  logic            o_ready;
  logic [1:0]      i_op;
  logic [2:0]      i_pw;
  logic [LW-1:0]   i_shamt;
  logic [XLEN-1:0] i_rs1;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_illegal;

  modport master (
    output i_valid, i_op, i_pw, i_shamt, i_rs1, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_illegal
  );

  modport slave (
    input  i_valid, i_op, i_pw, i_shamt, i_rs1, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_illegal
  );
endinterface

// File: rtl/xc_pshift_seq.sv
// Iterative packed-lane shifter (SLL/SRL, ROR when XC_PSHIFT_ROT_EN is defined), SPC bits per cycle.
// Latency 1+ceil(eff/SPC) from accept; one op in flight, result held in DONE until i_ready; i_flush aborts.
module xc_pshift_seq #(
  parameter int XLEN = 32,
  parameter int SPC  = 4
) (
  input  logic             g_clk,
  input  logic             g_reset,
  xc_pshift_seq_if.slave   bus
);
  localparam int LW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] data_q;
  logic [LW-1:0]   rem_q;
  logic [1:0]      op_q;
  logic [2:0]      pw_q;
  logic            illegal_q;

  logic [LW-1:0]   lane_msk;
  logic [LW-1:0]   eff;
  logic [LW-1:0]   step;
  logic            req_illegal;
  logic            accept;

  // Whole-word shift, then mask off bits that crossed a lane boundary.
  function automatic logic [XLEN-1:0] lane_shift(
    input logic [XLEN-1:0] x,
    input logic [1:0]      op,
    input logic [2:0]      pw,
    input logic [LW-1:0]   s
  );
    int              w;
    int              si;
    logic [XLEN-1:0] keep_lo;
    logic [XLEN-1:0] keep_hi;
    logic [XLEN-1:0] res;
    w  = XLEN >> pw;
    si = int'(s);
    for (int i = 0; i < XLEN; i++) begin
      keep_lo[i] = (((i & (w - 1)) + si) < w);
      keep_hi[i] = ((i & (w - 1)) >= si);
    end
    case (op)
      2'b00:   res = (x << si) & keep_hi;
      2'b01:   res = (x >> si) & keep_lo;
`ifdef XC_PSHIFT_ROT_EN
      2'b10:   res = ((x >> si) & keep_lo) | ((x << (w - si)) & ~keep_lo);
`endif
      default: res = x;
    endcase
    return res;
  endfunction

  always_comb begin
    lane_msk = LW'((XLEN >> bus.i_pw) - 1);
    eff      = bus.i_shamt & lane_msk;
`ifdef XC_PSHIFT_ROT_EN
    req_illegal = (bus.i_op == 2'b11) || (int'(bus.i_pw) > LW - 1);
`else
    req_illegal = bus.i_op[1] || (int'(bus.i_pw) > LW - 1);
`endif
    step = (int'(rem_q) < SPC) ? rem_q : LW'(SPC);
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.o_ready  = 1'b0;
    bus.o_valid  = 1'b0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        bus.o_ready = !bus.i_flush;
        accept      = bus.i_valid && !bus.i_flush;
        if (accept) state_d = (req_illegal || eff == '0) ? DONE : BUSY;
      end
      BUSY: begin
        if (rem_q == step) state_d = DONE;
      end
      DONE: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.i_flush) state_d = IDLE;
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      data_q    <= '0;
      rem_q     <= '0;
      op_q      <= '0;
      pw_q      <= '0;
      illegal_q <= 1'b0;
    end else if (bus.i_flush) begin
      rem_q <= '0;
    end else if (accept) begin
      op_q      <= bus.i_op;
      pw_q      <= bus.i_pw;
      illegal_q <= req_illegal;
      rem_q     <= req_illegal ? '0 : eff;
      data_q    <= req_illegal ? '0 : bus.i_rs1;
    end else if (state_q == BUSY) begin
      data_q <= lane_shift(data_q, op_q, pw_q, step);
      rem_q  <= rem_q - step;
    end
  end

  assign bus.o_result  = data_q;
  assign bus.o_illegal = illegal_q;
endmodule

// File: tb/tb_xc_pshift_seq.sv
// Randomized and directed bench for xc_pshift_seq (XLEN=32, SPC=4) against a per-lane arithmetic model.
module tb_xc_pshift_seq;
  localparam int XLEN = 32;
  localparam int SPC  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xc_pshift_seq_if #(.XLEN(XLEN)) bus();

  xc_pshift_seq #(.XLEN(XLEN), .SPC(SPC)) dut (
    .g_clk   (clk),
    .g_reset (rst),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_illegal(input logic [1:0] op, input int pw);
`ifdef XC_PSHIFT_ROT_EN
    return (op == 2'd3) || (pw > 4);
`else
    return (op >= 2'd2) || (pw > 4);
`endif
  endfunction

  function automatic int ref_eff(input int pw, input int shamt);
    return shamt % (32 >> pw);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input int pw, input int shamt,
                                             input logic [31:0] rs1);
    int          w;
    int          e;
    logic [63:0] m, v, r, acc;
    if (ref_illegal(op, pw)) return 32'd0;
    w   = 32 >> pw;
    e   = shamt % w;
    m   = (64'd1 << w) - 64'd1;
    acc = 64'd0;
    for (int l = 0; l < 32 / w; l++) begin
      v = ({32'd0, rs1} >> (l * w)) & m;
      case (op)
        2'd0:    r = v << e;
        2'd1:    r = v >> e;
        default: r = (v >> e) | (v << (w - e));
      endcase
      acc = acc | ((r & m) << (l * w));
    end
    return acc[31:0];
  endfunction

  task automatic run_req(input logic [1:0] op, input int pw, input int shamt,
                         input logic [31:0] rs1, input int hold);
    int          lat;
    int          exp_lat;
    logic        exp_ill;
    logic [31:0] exp_res;
    logic [31:0] held;
    exp_ill = ref_illegal(op, pw);
    exp_res = ref_result(op, pw, shamt, rs1);
    exp_lat = exp_ill ? 1 : 1 + (ref_eff(pw, shamt) + SPC - 1) / SPC;
    lat = 0;
    while (!bus.o_ready && lat < 20) begin
      tick;
      lat++;
    end
    check("idle_ready", bus.o_ready, 1);
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_pw    = 3'(pw);
    bus.i_shamt = 5'(shamt);
    bus.i_rs1   = rs1;
    tick;
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 40) begin
      tick;
      lat++;
    end
    check("latency", lat, exp_lat);
    if (!bus.o_valid) return;
    check("result", bus.o_result, exp_res);
    check("illegal", bus.o_illegal, exp_ill);
    held = bus.o_result;
    for (int k = 0; k < hold; k++) begin
      tick;
      check("hold_valid", bus.o_valid, 1);
      check("hold_result", bus.o_result, held);
      check("hold_ready", bus.o_ready, 0);
    end
    bus.i_ready = 1'b1;
    tick;
    bus.i_ready = 1'b0;
    check("exit_valid", bus.o_valid, 0);
    check("exit_ready", bus.o_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_op    = 2'd0;
    bus.i_pw    = 3'd0;
    bus.i_shamt = 5'd0;
    bus.i_rs1   = 32'd0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    repeat (3) tick;
    check("rst_valid", bus.o_valid, 0);
    check("rst_result", bus.o_result, 0);
    check("rst_illegal", bus.o_illegal, 0);
    rst = 1'b0;
    tick;
    check("post_rst_ready", bus.o_ready, 1);

    run_req(2'd0, 2, 3, 32'h81422418, 0);
    check("sll_const", ref_result(2'd0, 2, 3, 32'h81422418), 32'h081020C0);
    run_req(2'd1, 1, 20, 32'h8000F00F, 1);
    run_req(2'd2, 3, 1, 32'h12345678, 0);
    run_req(2'd0, 5, 7, 32'hDEADBEEF, 0);
    run_req(2'd3, 2, 2, 32'hCAFEF00D, 0);
    run_req(2'd1, 0, 0, 32'h13579BDF, 0);
    run_req(2'd0, 0, 31, 32'hFFFFFFFF, 5);
    run_req(2'd1, 4, 1, 32'hAAAA5555, 2);

    // Flush on the 3rd BUSY cycle of a 31-bit shift.
    bus.i_valid = 1'b1;
    bus.i_op    = 2'd0;
    bus.i_pw    = 3'd0;
    bus.i_shamt = 5'd31;
    bus.i_rs1   = 32'h0000_0001;
    tick;
    bus.i_valid = 1'b0;
    tick;
    tick;
    bus.i_flush = 1'b1;
    #1;
    check("flush_ready_low", bus.o_ready, 0);
    tick;
    bus.i_flush = 1'b0;
    #1;
    check("flush_valid", bus.o_valid, 0);
    check("flush_ready", bus.o_ready, 1);
    for (int k = 0; k < 10; k++) begin
      tick;
      check("flush_no_result", bus.o_valid, 0);
    end

    // Flush in IDLE must block a simultaneous request.
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_op    = 2'd0;
    bus.i_pw    = 3'd2;
    bus.i_shamt = 5'd0;
    #1;
    check("idle_flush_ready", bus.o_ready, 0);
    tick;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    #1;
    check("idle_flush_noacc", bus.o_ready, 1);
    tick;
    check("idle_flush_novalid", bus.o_valid, 0);

    // Reset in BUSY and in DONE discards the operation.
    bus.i_valid = 1'b1;
    bus.i_op    = 2'd1;
    bus.i_pw    = 3'd0;
    bus.i_shamt = 5'd30;
    tick;
    bus.i_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      check("rst_busy_novalid", bus.o_valid, 0);
    end
    bus.i_valid = 1'b1;
    bus.i_op    = 2'd3;
    tick;
    bus.i_valid = 1'b0;
    check("done_before_rst", bus.o_valid, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    check("rst_done_novalid", bus.o_valid, 0);
    check("rst_done_ready", bus.o_ready, 1);

    for (int n = 0; n < 60; n++) begin
      run_req(2'($urandom_range(0, 3)), int'($urandom_range(0, 5)), int'($urandom_range(0, 31)),
              32'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/xc_pshift_seq.md
XC_PSHIFT_SEQ -- requirements
Module: xc_pshift_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter SPC, default 4, maximum bits shifted per cycle; power of two, 1..XLEN.
REQ-003 SHALL have ports, clock and reset first:
- g_clk  in  1  clock
- g_reset  in  1  asynchronous active-high reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid & o_ready
- i_op  in  2  00 SLL, 01 SRL, 10 ROR, 11 reserved
- i_pw  in  3  pack width; lane width = XLEN >> i_pw
- i_shamt  in  log2(XLEN)  shift amount
- i_rs1  in  XLEN  operand
- i_flush  in  1  abort in-flight operation
- o_valid  out  1  result valid
- i_ready  in  1  result consumed when o_valid & i_ready
- o_result  out  XLEN  packed result
- o_illegal  out  1  request was illegal; qualified by o_valid

Function
REQ-004 SHALL be a 3-state FSM: IDLE, BUSY, DONE.
REQ-005 o_ready SHALL be 1 only in IDLE with i_flush low.
REQ-006 Effective shift SHALL be i_shamt & (laneW-1); lanes SHALL be independent; SLL/SRL zero-fill per lane; ROR rotates right within each lane.
REQ-007 Request SHALL be illegal when i_op=11 or laneW<2, i.e. i_pw > log2(XLEN)-1.
REQ-008 On accept, the block SHALL capture operands and set remaining=effective shift.
REQ-009 Illegal requests or remaining=0 SHALL go straight to DONE.
REQ-010 Otherwise the block SHALL go to BUSY.
REQ-011 In BUSY, each cycle SHALL shift every lane by step=min(remaining,SPC) and set remaining-=step; on remaining reaching 0 the FSM SHALL go to DONE.
REQ-012 Accept-to-o_valid latency SHALL be 1+ceil(eff/SPC) cycles.
REQ-013 In DONE, o_valid SHALL be 1; o_result and o_illegal SHALL be held stable until i_ready.
REQ-014 DONE SHALL go to IDLE on i_ready.
REQ-015 No new request SHALL be accepted in the same cycle as DONE exits.
REQ-016 Illegal result SHALL be o_result=0, o_illegal=1.
REQ-017 Legal result SHALL have o_illegal=0.
REQ-018 When legal and eff=0, o_result SHALL equal i_rs1.
REQ-019 i_flush SHALL have top priority in any state: next state IDLE, o_valid low next cycle, no result for the aborted operation.
REQ-020 i_flush in IDLE SHALL block acceptance that cycle.
REQ-021 o_valid and o_ready SHALL be driven from registered state only, with no combinational path from i_valid or i_ready.

Reset
REQ-022 While g_reset is high, the FSM SHALL be IDLE and o_valid=0, o_result=0, o_illegal=0, internal counter=0.
REQ-023 o_ready SHALL be 1 from the first cycle after g_reset deasserts.
REQ-024 Reset asserted mid-BUSY or mid-DONE SHALL discard the operation, with no o_valid after release.

Configuration
REQ-025 Macro XC_PSHIFT_ROT_EN defined: ROR (i_op=10) SHALL be supported per REQ-006.
REQ-026 Macro undefined: i_op=10 SHALL be illegal per REQ-016 and rotate logic SHALL be absent.

Verification (XLEN=32, SPC=4)
REQ-027 SLL, pw=2, rs1=0x81422418, shamt=3 -> o_valid 2 cycles after accept, o_result=0x081020C0, o_illegal=0.
REQ-028 SRL, pw=1, rs1=0x8000F00F, shamt=20 (eff 4) -> o_result=0x08000F00, latency 2.
REQ-029 ROR, pw=3, rs1=0x12345678, shamt=1 -> 0x8192A3B4 with XC_PSHIFT_ROT_EN; without it o_result=0, o_illegal=1, latency 1.
REQ-030 SLL, pw=0, shamt=31 (8 BUSY cycles), i_flush at 3rd BUSY cycle -> IDLE next cycle, no o_valid, o_ready=1.
REQ-031 pw=5 or i_op=11 -> illegal, latency 1. shamt=0 -> o_result=rs1, latency 1. i_ready low 5 cycles in DONE -> o_result stable, o_ready=0 throughout.
